// File: rtl/mcpu_pkg.sv
// Shared definitions for the mcpu bus peripherals.
// Contents:
//   UART_BASE_DEFAULT   default base address of the UART window
//   UART_DATA/UART_STAT register offsets inside the window
//   STAT_*              bit positions inside the STATUS byte
//   uart_state_t        transmitter FSM state encoding
//   uart_pack_status    assembles the STATUS byte from its flags
package mcpu_pkg;

    localparam logic [15:0] UART_BASE_DEFAULT = 16'hFF00;

    localparam logic [15:0] UART_DATA = 16'h0000;
    localparam logic [15:0] UART_STAT = 16'h0001;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    function automatic logic [7:0] uart_pack_status(
        input logic ovf,
        input logic empty,
        input logic full,
        input logic busy
    );
        logic [7:0] st;
        st             = 8'h00;
        st[STAT_OVF]   = ovf;
        st[STAT_EMPTY] = empty;
        st[STAT_FULL]  = full;
        st[STAT_BUSY]  = busy;
        return st;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
// A push while full is accepted only if a pop happens in the same cycle.
// A pop while empty is ignored. dout shows the head entry combinationally.
// Ports:
//   clk, rst      clock and synchronous reset
//   push, din     write request and data
//   pop, dout     read request and head data
//   full, empty   occupancy flags
//   count         number of stored entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // Qualify requests: pop needs data, push needs room or a simultaneous pop.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && (!full || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus.
// Offset 0 (DATA) queues a byte; offset 1 (STATUS) reads {4'b0,ovf,empty,full,busy}
// and any write to it clears the sticky overflow flag.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   address    CPU bus address
//   din        CPU write data
//   read       1 = read cycle, 0 = write cycle
//   dout       combinational read data, 8'h00 when not selected
//   sel        combinational window hit, used by the top level for read muxing
//   txd        registered serial output, idles high
module uart_tx_mmio
    import mcpu_pkg::*;
#(
    parameter logic [15:0] BASE  = UART_BASE_DEFAULT,
    parameter int          DIV   = 16,
    parameter int          DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [7:0]  din,
    input  logic        read,
    output logic [7:0]  dout,
    output logic        sel,
    output logic        txd
);

    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    // Bus decode
    logic [15:0]  offset_s;
    logic         wr_s;
    logic         wr_first_s;
    logic         push_s;
    logic         ovf_clr_s;
    logic         ovf_set_s;
    logic         wr_prev_r;
    logic [15:0]  addr_prev_r;
    logic         ovf_r;
    logic [7:0]   status_s;

    // FIFO
    logic [7:0]    fifo_dout_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic          has_data_s;

    // Transmitter
    uart_state_t   state_r;
    uart_state_t   state_n;
    logic [BW-1:0] baud_r;
    logic [BW-1:0] baud_n;
    logic [2:0]    bit_r;
    logic [2:0]    bit_n;
    logic [7:0]    shift_r;
    logic [7:0]    shift_n;
    logic          txd_r;
    logic          txd_n;
    logic          pop_s;
    logic          baud_last_s;

    assign offset_s = address - BASE;
    assign sel      = (offset_s[15:1] == 15'd0);
    assign wr_s     = sel & ~read;

    // A held write repeats the same strobe and address; only its first cycle counts.
    assign wr_first_s = wr_s & ~(wr_prev_r & (addr_prev_r == address));
    assign push_s     = wr_first_s & (offset_s == UART_DATA);
    assign ovf_clr_s  = wr_first_s & (offset_s == UART_STAT);
    assign ovf_set_s  = push_s & fifo_full_s & ~pop_s;

    assign has_data_s  = (fifo_count_s != {CW{1'b0}});
    assign baud_last_s = (baud_r == BAUD_LAST);
    assign status_s    = uart_pack_status(ovf_r, fifo_empty_s, fifo_full_s,
                                          (state_r != ST_IDLE));
    assign txd         = txd_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (din),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Read data mux: only a STATUS read returns non-zero data.
    always_comb begin
        dout = 8'h00;
        if (sel && read && (offset_s == UART_STAT)) begin
            dout = status_s;
        end else begin
            dout = 8'h00;
        end
    end

    // Previous-cycle strobe/address copy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prev_r   <= 1'b0;
            addr_prev_r <= 16'h0000;
            ovf_r       <= 1'b0;
        end else begin
            wr_prev_r   <= wr_s;
            addr_prev_r <= address;
            if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end else if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Transmitter next-state: baud counter restarts at every state or bit change.
    always_comb begin
        state_n = state_r;
        baud_n  = baud_r;
        bit_n   = bit_r;
        shift_n = shift_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (has_data_s) begin
                    pop_s   = 1'b1;
                    shift_n = fifo_dout_s;
                    baud_n  = {BW{1'b0}};
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_n  = {BW{1'b0}};
                    bit_n   = 3'd0;
                    state_n = ST_DATA;
                end else begin
                    baud_n = baud_r + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_n = {BW{1'b0}};
                    if (bit_r == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_n   = bit_r + 3'd1;
                        shift_n = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    baud_n = baud_r + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_n = {BW{1'b0}};
                    // Chain directly into the next start bit to avoid an idle gap.
                    if (has_data_s) begin
                        pop_s   = 1'b1;
                        shift_n = fifo_dout_s;
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    baud_n = baud_r + BW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                baud_n  = {BW{1'b0}};
                bit_n   = 3'd0;
            end
        endcase
    end

    // Line level derived from the state being entered so txd is a clean flop output.
    always_comb begin
        txd_n = 1'b1;
        case (state_n)
            ST_START: txd_n = 1'b0;
            ST_DATA:  txd_n = shift_n[0];
            default:  txd_n = 1'b1;
        endcase
    end

    // Transmitter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            baud_r  <= {BW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_n;
            baud_r  <= baud_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            txd_r   <= txd_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: a queue-level transmitter model predicts which
// bytes are sent and on which cycle each frame starts; a serial monitor
// decodes txd and checks every frame against those predictions.
module tb_uart_tx_mmio;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic        read = 1'b1;
    logic [7:0]  dout;
    logic        sel;
    logic        txd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_tx_mmio #(
        .BASE  (16'hFF00),
        .DIV   (DIV),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .din     (din),
        .read    (read),
        .dout    (dout),
        .sel     (sel),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  mq[$];        // bytes waiting in the FIFO
    logic [7:0]  sb_byte[$];   // expected frames: byte
    int          sb_start[$];  // expected frames: cycle of start bit
    logic        m_ovf = 1'b0;
    logic        m_active = 1'b0;
    int          m_fs = 0;
    logic        m_prev_wr = 1'b0;
    logic [15:0] m_prev_addr = 16'h0000;
    logic        m_wr;
    logic        m_first;

    function automatic logic [7:0] exp_status();
        return {4'b0000, m_ovf, (mq.size() == 0), (mq.size() == DEPTH), m_active};
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            mq.delete();
            sb_byte.delete();
            sb_start.delete();
            m_ovf = 1'b0;
            m_active = 1'b0;
            m_prev_wr = 1'b0;
            m_prev_addr = 16'h0000;
        end else begin
            // A new frame starts when the line is free (idle, or a frame just ended).
            if ((!m_active || cyc == m_fs + FRAME) && mq.size() > 0) begin
                sb_byte.push_back(mq.pop_front());
                sb_start.push_back(cyc);
                m_fs = cyc;
                m_active = 1'b1;
            end else if (m_active && cyc == m_fs + FRAME) begin
                m_active = 1'b0;
            end
            m_wr = (address == 16'hFF00 || address == 16'hFF01) && !read;
            m_first = m_wr && !(m_prev_wr && m_prev_addr == address);
            if (m_first && address == 16'hFF00) begin
                if (mq.size() < DEPTH) mq.push_back(din);
                else m_ovf = 1'b1;
            end
            if (m_first && address == 16'hFF01) m_ovf = 1'b0;
            m_prev_wr = m_wr;
            m_prev_addr = address;
        end
    end

    // ---------------- serial monitor ----------------
    logic       mon_busy = 1'b0;
    int         mon_s = 0;
    int         mon_off;
    logic [7:0] mon_b = 8'h00;
    logic [7:0] mon_eb;
    int         mon_es;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (txd === 1'b0) begin
                mon_busy = 1'b1;
                mon_s = cyc;
            end
        end else begin
            mon_off = cyc - mon_s;
            if (mon_off == DIV / 2) chk("start_bit", {31'd0, txd}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                if (mon_off == DIV * (1 + i) + DIV / 2) mon_b[i] = txd;
            end
            if (mon_off == 9 * DIV + DIV / 2) begin
                chk("stop_bit", {31'd0, txd}, 32'd1);
                if (sb_byte.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got byte %0h at cyc %0d, none expected", mon_b, mon_s);
                end else begin
                    mon_eb = sb_byte.pop_front();
                    mon_es = sb_start.pop_front();
                    chk("frame_byte", {24'd0, mon_b}, {24'd0, mon_eb});
                    chk("frame_start", mon_s, mon_es);
                end
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            address = 16'h0000;
            read = 1'b1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold);
        repeat (hold) begin
            @(negedge clk);
            address = a;
            read = 1'b0;
            din = d;
        end
    endtask

    task automatic rd_stat();
        @(negedge clk);
        address = 16'hFF01;
        read = 1'b1;
        #1;
        chk("status", {24'd0, dout}, {24'd0, exp_status()});
    endtask

    task automatic drain(input int lim);
        int g;
        g = 0;
        while ((m_active || mq.size() != 0) && g < lim) begin
            rd_stat();
            g++;
        end
        if (g >= lim) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d cycles busy, limit %0d", g, lim);
        end
        idle(3);
    endtask

    logic [15:0] outside [4] = '{16'h00FF, 16'hFEFF, 16'hFF02, 16'h0000};

    initial begin
        int g;
        int r;
        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        address = 16'hFF01;
        read = 1'b1;
        #1;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_status", {24'd0, dout}, 32'h04);
        chk("reset_sel", {31'd0, sel}, 32'd1);

        // Single byte A5, status polled through the whole frame
        wr(16'hFF00, 8'hA5, 1);
        repeat (FRAME + 4) rd_stat();
        drain(100);

        // Write held for three cycles: one frame only
        wr(16'hFF00, 8'h55, 3);
        repeat (6) rd_stat();
        drain(200);

        // Six separate writes: one in flight, four queued, one dropped
        for (int i = 0; i < 6; i++) begin
            wr(16'hFF00, 8'h10 + 8'(i), 1);
            idle(1);
        end
        @(negedge clk);
        address = 16'hFF01;
        read = 1'b1;
        #1;
        chk("overflow_status", {24'd0, dout}, 32'h0B);
        wr(16'hFF01, 8'hFF, 1);
        @(negedge clk);
        address = 16'hFF01;
        read = 1'b1;
        #1;
        chk("ovf_cleared", {31'd0, dout[3]}, 32'd0);
        chk("status_after_clear", {24'd0, dout}, {24'd0, exp_status()});
        drain(400);

        // Reset in the middle of bit 3 with a second byte queued
        wr(16'hFF00, 8'h3C, 1);
        idle(1);
        wr(16'hFF00, 8'hC3, 1);
        g = 0;
        while (!(m_active && (cyc - m_fs) == 17) && g < 100) begin
            @(negedge clk);
            address = 16'h0000;
            read = 1'b1;
            g++;
        end
        if (g >= 100) begin
            total++;
            bad++;
            $display("FAIL bit3_wait: got no frame in %0d cycles", g);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        address = 16'hFF01;
        read = 1'b1;
        #1;
        chk("midframe_reset_txd", {31'd0, txd}, 32'd1);
        chk("midframe_reset_status", {24'd0, dout}, 32'h04);
        repeat (2 * FRAME) rd_stat();

        // Access outside the window
        @(negedge clk);
        address = 16'h00FF;
        read = 1'b0;
        din = 8'h77;
        #1;
        chk("outside_wr_sel", {31'd0, sel}, 32'd0);
        chk("outside_wr_dout", {24'd0, dout}, 32'h00);
        @(negedge clk);
        read = 1'b1;
        #1;
        chk("outside_rd_sel", {31'd0, sel}, 32'd0);
        chk("outside_rd_dout", {24'd0, dout}, 32'h00);
        rd_stat();
        chk("outside_no_push", {24'd0, dout}, 32'h04);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                wr(16'hFF00, 8'($urandom), $urandom_range(1, 3));
            end else if (r == 5) begin
                wr(16'hFF01, 8'($urandom), $urandom_range(1, 2));
            end else if (r == 6) begin
                rd_stat();
            end else if (r == 7) begin
                @(negedge clk);
                address = outside[$urandom_range(0, 3)];
                read = 1'($urandom);
                din = 8'($urandom);
                #1;
                chk("rand_outside_sel", {31'd0, sel}, 32'd0);
                chk("rand_outside_dout", {24'd0, dout}, 32'h00);
            end else begin
                idle($urandom_range(1, 20));
            end
        end
        drain(2000);
        g = 0;
        while (mon_busy && g < 100) begin
            idle(1);
            g++;
        end
        chk("scoreboard_empty", sb_byte.size(), 32'd0);
        chk("final_status", {24'd0, exp_status()} | 32'd0, {24'd0, 8'h00} | {24'd0, 4'b0000, m_ovf, 3'b100});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped 8N1 UART transmitter that sits on the `cpu` data bus next to `sram`, decoding its own address window and consuming CPU store cycles. Bytes written by the CPU queue in a small FIFO and are serialised on `txd` at a fixed baud divisor. CPU loads return a status byte, which lets firmware poll for space instead of relying on fixed delays.

## Interface
Parameters:
- `BASE`, 16'hFF00, window base address; the block decodes `BASE` and `BASE+1`.
- `DIV`, 16, clock cycles per serial bit; minimum 2.
- `DEPTH`, 4, FIFO entries; must be a power of 2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `address`  in  16  CPU bus address.
- `din`  in  8  CPU write data (the CPU's `dout`).
- `read`  in  1  1 = read cycle, 0 = write cycle; same polarity as the `sram` `RW`.
- `dout`  out  8  read data; combinational; 8'h00 when not selected.
- `sel`  out  1  combinational; high when `address` is in the window. The top level uses it to mux `dout` against `sram`.
- `txd`  out  1  serial output; idles high.

## Operation
Register map (offset = `address - BASE`):
- 0, DATA: a write pushes `din` into the FIFO. A read returns 8'h00.
- 1, STATUS: a read returns {4'b0, ovf, empty, full, busy}.
  - `busy` = FSM not in IDLE.
  - `full` and `empty` reflect the FIFO.
  - `ovf` is sticky. Writing any value to offset 1 clears it.

Write strobe:
- A write is a cycle with `sel` & !`read`.
- Only the first cycle of a write takes effect; the first cycle is detected against a registered copy of the previous cycle's strobe and address.
- A CPU that holds a write for several cycles therefore pushes exactly once.
- Write when `full` and no pop in that cycle: the byte is dropped and `ovf` is set.
- Write when `full` and a pop in the same cycle: the byte is accepted.

Transmitter FSM (states IDLE, START, DATA, STOP):
- IDLE: `txd`=1. When the FIFO is not empty, pop into the shift register and go to START.
- START: `txd`=0 for `DIV` cycles, then go to DATA with bit index 0.
- DATA: `txd`=shift[0] for `DIV` cycles per bit, shifting right each bit, LSB first. After bit 7, go to STOP.
- STOP: `txd`=1 for `DIV` cycles. Then, if the FIFO is not empty, pop and go straight to START, so back-to-back frames have no idle gap. Otherwise go to IDLE.

Counters and widths:
- Baud counter width is `$clog2(DIV)`; it reloads at 0 on every state or bit change.
- Bit index is 3 bits and does not wrap past 7.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits.

## Timing
Reset values (on the edge where `rst`=1):
- FSM = IDLE, `txd`=1.
- FIFO empty, `ovf`=0.
- Previous-strobe register = 0.
- `dout` and `sel` are combinational and have no reset state.

Latency:
- A push at edge N into an empty FIFO with the FSM in IDLE: the pop happens at edge N+1, and `txd` is low from edge N+1.
- A frame lasts exactly 10×`DIV` cycles.

Boundary conditions:
- STATUS reflects state after the most recent edge, with no read side effects.
- Reset asserted mid-frame: `txd`=1 from that edge, queued bytes are discarded, and no partial frame resumes.
- Push and pop in the same cycle: count is unchanged.

## Structure
- Shared package `mcpu_pkg` holds:
  - register offsets `UART_DATA` and `UART_STAT`;
  - STATUS bit indices;
  - the FSM state enum `uart_state_t`;
  - the default `BASE`.
- One sub-module, `sync_fifo` (parameters WIDTH and DEPTH, synchronous `rst`), with push, pop, din, dout, full, empty and count. It is reusable for a later receiver.

## Test plan
- Reset with `DIV`=4: `txd`=1, then read 16'hFF01 → 8'h04 (`empty` only).
- Write 8'hA5 to 16'hFF00 → `txd` sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1. `busy` is set from the next edge and clears 40 cycles after the start bit.
- Hold a write of 8'h55 for 3 cycles → exactly one frame is sent and FIFO count never exceeds 1.
- Issue 6 single-cycle writes back-to-back while idle:
  - the 1st is popped immediately and the next 4 fill the FIFO (`full`=1);
  - the 6th is dropped and STATUS reads 8'h0B;
  - writing to 16'hFF01 makes bit 3 read 0.
  - 5 frames go out with no idle gap.
- Assert `rst` during bit 3 of a frame → `txd`=1 on the next edge, STATUS reads 8'h04, and no further start bit appears.
- Access 16'h00FF → `sel`=0, `dout`=8'h00, FIFO is unchanged.
